vector_execute_stage: RTL and testbench

Execute stage of the 8-lane vector pipeline, directly downstream of the ID/EX register buffer. It consumes the buffered operands, immediate and control fields, and computes a per-lane ALU result. It registers the result together with the forwarded control into the EX/MEM boundary. Multiply is lane-serial and multi-cycle: the stage raises `stall` so the upstream buffer holds its contents (`load = ~stall`) until the vector product is complete.

---
 rtl/vector_execute_stage.sv | 108 ++++++++++
 tb/tb_vector_execute_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_execute_stage.sv
// vector_execute_stage: 8-lane vector ALU stage feeding the EX/MEM registers,
// with a lane-serial multiply that stalls the ID/EX buffer until done.
module vector_execute_stage #(
  parameter int N = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [7:0][N-1:0]  rd1,
  input  logic [7:0][N-1:0]  rd2,
  input  logic [7:0][N-1:0]  extend,
  input  logic [1:0]         ALUSrc,
  input  logic [2:0]         ALUControl,
  input  logic               RegWrite,
  input  logic               MemtoReg,
  input  logic               MemWrite,
  input  logic [3:0]         WA3,
  input  logic               flush,
  output logic               stall,
  output logic [7:0][N-1:0]  result,
  output logic [7:0][N-1:0]  wdata,
  output logic               RegWriteO,
  output logic               MemtoRegO,
  output logic               MemWriteO,
  output logic [3:0]         WA3O,
  output logic               valid_out
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [7:0][N-1:0] r_acc, r_result, r_wdata;
  logic [3:0]       r_wa;
  logic             r_rw, r_mtr, r_mw, r_valid;
  logic [7:0][N-1:0] w_b, w_alu, w_res;
  logic [N-1:0]     w_prod;
  logic             w_is_mul, w_load;
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_b[i] = ALUSrc == 2'b01 ? extend[i] : ALUSrc == 2'b10 ? extend[0] : rd2[i];
      case (ALUControl)
        3'b000:  w_alu[i] = rd1[i] + w_b[i];
        3'b001:  w_alu[i] = rd1[i] - w_b[i];
        3'b010:  w_alu[i] = rd1[i] & w_b[i];
        3'b011:  w_alu[i] = rd1[i] | w_b[i];
        3'b100:  w_alu[i] = rd1[i] ^ w_b[i];
        3'b101:  w_alu[i] = 32'(w_b[i][4:0]) >= N ? '0 : rd1[i] << w_b[i][4:0];
        3'b111:  w_alu[i] = w_b[i];
        default: w_alu[i] = '0;
      endcase
    end
  end
  // Only the lane selected by the counter is multiplied each cycle.
  assign w_prod   = rd1[r_cnt] * w_b[r_cnt];
  assign w_is_mul = ALUControl == 3'b110;
  assign stall    = !flush && (r_state == MUL ? r_cnt != 3'd7 : valid_in && w_is_mul);
  assign w_load   = !flush && (r_state == MUL ? r_cnt == 3'd7 : valid_in && !w_is_mul);
  assign w_res    = r_state == MUL ? {w_prod, r_acc[6:0]} : w_alu;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_wdata  <= '0;
      r_wa     <= '0;
      r_rw     <= 1'b0;
      r_mtr    <= 1'b0;
      r_mw     <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_result <= '0;
      r_wdata  <= '0;
      r_wa     <= '0;
      r_rw     <= 1'b0;
      r_mtr    <= 1'b0;
      r_mw     <= 1'b0;
      r_valid  <= 1'b0;
      if (w_load) begin
        r_result <= w_res;
        r_wdata  <= rd2;
        r_wa     <= WA3;
        r_rw     <= RegWrite;
        r_mtr    <= MemtoReg;
        r_mw     <= MemWrite;
        r_valid  <= 1'b1;
      end
      if (flush) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_acc   <= '0;
      end else if (r_state == MUL) begin
        r_acc[r_cnt] <= w_prod;
        r_cnt        <= r_cnt + 3'd1;
        r_state      <= r_cnt == 3'd7 ? IDLE : MUL;
      end else if (valid_in && w_is_mul) begin
        r_state <= MUL;
        r_cnt   <= '0;
      end
    end
  end
  assign result    = r_result;
  assign wdata     = r_wdata;
  assign WA3O      = r_wa;
  assign RegWriteO = r_rw & r_valid;
  assign MemtoRegO = r_mtr & r_valid;
  assign MemWriteO = r_mw & r_valid;
  assign valid_out = r_valid;
endmodule

// File: tb/tb_vector_execute_stage.sv
// tb_vector_execute_stage: table-driven single-cycle ops plus hand-written
// multiply, flush, reset and bubble sequences, checked through a scoreboard.
module tb_vector_execute_stage;
  localparam int N = 20;
  typedef logic [7:0][N-1:0] vec_t;
  typedef struct {
    logic [1:0] src;
    logic [2:0] op;
    vec_t       a, b, e;
    logic       rw, mtr, mw;
    logic [3:0] wa;
    vec_t       exp;
  } tv_t;
  typedef struct {
    vec_t       res, wd;
    logic [3:0] wa;
    logic       rw, mtr, mw;
  } sb_t;

  logic       clk, reset, valid_in, flush;
  vec_t       rd1, rd2, extend, result, wdata;
  logic [1:0] ALUSrc;
  logic [2:0] ALUControl;
  logic       RegWrite, MemtoReg, MemWrite, stall;
  logic       RegWriteO, MemtoRegO, MemWriteO, valid_out;
  logic [3:0] WA3, WA3O;

  vector_execute_stage #(.N(N)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .rd1(rd1), .rd2(rd2),
    .extend(extend), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .WA3(WA3),
    .flush(flush), .stall(stall), .result(result), .wdata(wdata),
    .RegWriteO(RegWriteO), .MemtoRegO(MemtoRegO), .MemWriteO(MemWriteO),
    .WA3O(WA3O), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  sb_t  q[$];
  sb_t  s_mon;
  tv_t  tv[9];
  vec_t ta, tb_b, te, tx;

  function automatic vec_t rep(input logic [N-1:0] v);
    vec_t r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] op,
                       input vec_t a, input vec_t b, input vec_t e,
                       input logic rw, input logic mtr, input logic mw, input logic [3:0] wa);
    valid_in = v; ALUSrc = src; ALUControl = op; rd1 = a; rd2 = b; extend = e;
    RegWrite = rw; MemtoReg = mtr; MemWrite = mw; WA3 = wa;
  endtask

  task automatic push(input vec_t res, input vec_t wd, input logic [3:0] wa,
                      input logic rw, input logic mtr, input logic mw);
    sb_t s;
    s.res = res; s.wd = wd; s.wa = wa; s.rw = rw; s.mtr = mtr; s.mw = mw;
    q.push_back(s);
  endtask

  task automatic run_mul(input vec_t a, input vec_t b, input vec_t exp,
                         input logic [3:0] wa, input logic prev);
    drive(1'b1, 2'b00, 3'b110, a, b, '0, 1'b1, 1'b0, 1'b0, wa);
    push(exp, b, wa, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("mul_stall_c%0d", c), stall, c < 8);
      chk($sformatf("mul_vout_c%0d", c), valid_out, c == 0 ? prev : 1'b0);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid_out: got 1 expected 0");
      end else begin
        s_mon = q.pop_front();
        chk("sb_result", result, s_mon.res);
        chk("sb_ctrl", {wdata, WA3O, RegWriteO, MemtoRegO, MemWriteO},
            {s_mon.wd, s_mon.wa, s_mon.rw, s_mon.mtr, s_mon.mw});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ta = rep(5); ta[0] = 20'hFFFFF; tx = rep(6); tx[0] = 20'h00000;
    tv[0] = '{2'b00, 3'b000, ta, rep(1), rep(0), 1'b1, 1'b0, 1'b0, 4'd3, tx};
    ta = rep(10); ta[1] = 20'h0; tx = rep(9); tx[1] = 20'hFFFFF;
    tv[1] = '{2'b00, 3'b001, ta, rep(1), rep(0), 1'b1, 1'b0, 1'b0, 4'd4, tx};
    te = rep(7); te[0] = 20'd3;
    tv[2] = '{2'b10, 3'b101, rep(1), rep(9), te, 1'b1, 1'b0, 1'b0, 4'd5, rep(8)};
    te = rep(20); te[1] = 20'd19; te[2] = 20'd31; te[3] = 20'h20;
    tx = rep(0); tx[1] = 20'h80000; tx[3] = 20'h1;
    tv[3] = '{2'b01, 3'b101, rep(1), rep(2), te, 1'b1, 1'b0, 1'b0, 4'd6, tx};
    tv[4] = '{2'b00, 3'b010, rep(20'hF0F0F), rep(20'h0FF00), rep(0), 1'b0, 1'b0, 1'b1, 4'd7, rep(20'h00F00)};
    tv[5] = '{2'b11, 3'b011, rep(20'hF0000), rep(20'h0000F), rep(3), 1'b1, 1'b1, 1'b0, 4'd8, rep(20'hF000F)};
    tv[6] = '{2'b00, 3'b100, rep(20'hFFFFF), rep(20'h12345), rep(0), 1'b1, 1'b0, 1'b0, 4'd9, rep(20'hEDCBA)};
    tv[7] = '{2'b01, 3'b111, rep(7), rep(0), rep(20'hABCDE), 1'b1, 1'b0, 1'b0, 4'd10, rep(20'hABCDE)};
    te = rep(5); te[0] = 20'h100;
    tv[8] = '{2'b10, 3'b000, rep(20'h10), rep(4), te, 1'b1, 1'b0, 1'b0, 4'd11, rep(20'h110)};

    reset = 1'b0;
    flush = 1'b0;
    drive(1'b1, 2'b00, 3'b000, rep(5), rep(6), rep(7), 1'b1, 1'b1, 1'b1, 4'hA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_wdata", wdata, '0);
    chk("rst_wa3o", WA3O, 4'h0);
    chk("rst_ctrl", {RegWriteO, MemtoRegO, MemWriteO}, 3'b000);
    chk("rst_vout", valid_out, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int k = 0; k < 9; k++) begin
      drive(1'b1, tv[k].src, tv[k].op, tv[k].a, tv[k].b, tv[k].e,
            tv[k].rw, tv[k].mtr, tv[k].mw, tv[k].wa);
      push(tv[k].exp, tv[k].b, tv[k].wa, tv[k].rw, tv[k].mtr, tv[k].mw);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("table_drain", q.size(), 0);

    for (int i = 0; i < 8; i++) begin
      ta[i] = N'(i + 2);
      tx[i] = N'((i + 2) * 4096);
    end
    run_mul(ta, rep(20'h1000), tx, 4'd12, 1'b0);
    ta = rep(20'h800); ta[3] = 20'h801;
    tx = rep(0); tx[3] = 20'h00800;
    run_mul(ta, rep(20'h800), tx, 4'd13, 1'b1);
    valid_in = 1'b0;
    @(negedge clk);
    chk("mul2_vout", valid_out, 1'b1);
    @(posedge clk); #1;
    chk("mul_drain", q.size(), 0);

    drive(1'b1, 2'b00, 3'b110, rep(3), rep(5), rep(0), 1'b1, 1'b0, 1'b0, 4'd14);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", stall, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b1, 2'b00, 3'b000, rep(2), rep(3), rep(0), 1'b1, 1'b0, 1'b0, 4'd15);
    push(rep(5), rep(3), 4'd15, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_stall", stall, 1'b0);
    chk("post_flush_vout", valid_out, 1'b0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("post_flush_add_vout", valid_out, 1'b1);
    @(posedge clk); #1;

    drive(1'b1, 2'b00, 3'b110, rep(3), rep(5), rep(0), 1'b1, 1'b0, 1'b0, 4'd2);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_vout", valid_out, 1'b0);
    chk("midrst_result", result, '0);
    repeat (10) @(posedge clk);
    #1;

    drive(1'b0, 2'b00, 3'b000, rep(1), rep(2), rep(0), 1'b1, 1'b1, 1'b1, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("bubble_vout", valid_out, 1'b0);
    chk("bubble_ctrl", {RegWriteO, MemtoRegO, MemWriteO}, 3'b000);
    chk("bubble_result", result, '0);
    chk("bubble_wdata", wdata, '0);
    chk("bubble_wa3o", WA3O, 4'h0);
    chk("final_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
